sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single-port SRAM macro (csb_n/we_n/addr/din/dout) between two requesters:
//  port 0 = UART command controller, port 1 = on-chip test/scrub engine.
//  Fair round-robin arbitration, one SRAM access per cycle, registered SRAM drive.
//  Read data is routed back only to the port that issued the read.
//  Optional post-reset clear of the whole array before any requester is served.
// PARAMETERS
//  ADDR_W      5   SRAM word address width (depth = 2**ADDR_W)
//  DATA_W      32  SRAM word width
//  INIT_CLEAR  1   1: write zero to every word after reset; 0: go straight to RUN
// PORTS
//  clk           in   1       single clock, all logic on posedge
//  rst           in   1       synchronous, active-high reset
//  p0_valid      in   1       port 0 request valid
//  p0_ready      out  1       port 0 request accepted this cycle (combinational)
//  p0_we         in   1       1 = write, 0 = read
//  p0_addr       in   ADDR_W  word address
//  p0_wdata      in   DATA_W  write data
//  p0_rvalid     out  1       one-cycle pulse, p0_rdata valid
//  p0_rdata      out  DATA_W  read data
//  p1_*          -    -       identical set for port 1
//  init_done     out  1       high once the array clear is complete (or INIT_CLEAR=0)
//  csb_n         out  1       SRAM chip select, active low
//  we_n          out  1       SRAM write enable, active low
//  addr          out  ADDR_W  SRAM address
//  sram_data_in  out  DATA_W  SRAM write data
//  sram_data_out in   DATA_W  SRAM read data, valid the cycle after a read is presented
// BEHAVIOUR
//  Reset values: p*_ready=0, p*_rvalid=0, p*_rdata=0, init_done=0, csb_n=1, we_n=1,
//   addr=0, sram_data_in=0. Round-robin pointer resets to port 0. Any in-flight read is dropped.
//  FSM: INIT -> RUN. INIT is entered on reset when INIT_CLEAR=1, otherwise RUN.
//  INIT: a counter steps 0 .. 2**ADDR_W-1, one write per cycle (csb_n=0, we_n=0, data 0).
//   In the cycle after the last write, init_done=1 and the FSM moves to RUN.
//   Both ready=0 throughout INIT. rst during INIT restarts the counter at 0.
//  RUN, arbitration: grant = valid port. If both ports are valid, the port named by the pointer wins.
//   After any grant, the pointer moves to the non-granted port, so there is no starvation.
//   p*_ready=1 only for the granted port. Handshake: an access completes when valid&ready.
//  Timing, handshake in cycle T:
//   T+1: registered csb_n=0, we_n=~we, addr, sram_data_in=wdata. When idle: csb_n=1, we_n=1.
//        addr and sram_data_in hold their previous value while idle.
//   T+2: sram_data_out valid for reads; captured into p*_rdata at end of T+2.
//   T+3: p*_rvalid=1 for exactly one cycle. Read latency = 3 cycles; writes get no response.
//  A 2-stage tag pipe {valid, is_read, port_id} follows every access to route the response.
//  Back-to-back accesses, one per cycle, are sustained with no bubbles. Responses are in order.
//  Conflicts between ports are resolved purely by grant order.
//   Example: P0 write then P1 read of the same address in the next cycle -> the read returns the new data.
//  p*_rdata holds its value between pulses. A valid that is dropped before ready is legal;
//   there is no obligation to hold a request.
// STRUCTURE
//  Shared header sram_arb_defs.vh holds: FSM state encodings (ST_INIT, ST_RUN),
//   port IDs (PORT0=1'b0, PORT1=1'b1), and the tag field layout.
//  Sub-module rr_arb2: 2-way round-robin grant with pointer register (clk, rst, req[1:0], gnt[1:0]).
//  Top level holds: the FSM, the init counter, the SRAM drive registers, the tag pipe and the response registers.
// TESTING
//  1. rst for 2 cycles, INIT_CLEAR=1
//     -> 32 consecutive writes of 0 (addr 0..31, we_n=0), ready=0 throughout;
//        init_done rises on cycle 33 and stays high.
//  2. RUN, P0 write addr 5 = 32'hDEADBEEF, then P0 read addr 5
//     -> p0_rvalid pulses 3 cycles after the read handshake with 32'hDEADBEEF; p1_rvalid stays 0.
//  3. Both ports hold valid for 6 cycles (P0 reads addr 1, P1 reads addr 2)
//     -> grants alternate P0,P1,P0,P1,P0,P1, one per cycle;
//        each port gets 3 rvalid pulses with the correct data.
//  4. P0 write addr 7 = 32'h12345678 and P1 read addr 7, both valid in the same cycle, pointer=P0
//     -> P0 granted first, P1 next cycle; P1 reads 32'h12345678.
//  5. Assert rst while INIT is at addr 17 and while a read is in flight
//     -> INIT restarts at 0, no p*_rvalid is emitted, all outputs are at reset values the next cycle.
//  6. INIT_CLEAR=0
//     -> init_done=1 the first cycle after reset; a P1 request is granted in that same cycle.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM states, port IDs, response tag layout.
package sram_port_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Tag that follows each SRAM access so its read data can be routed back.
  typedef struct packed {
    logic valid;
    logic is_read;
    logic port_id;
  } tag_t;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; pointer names the preferred port on contention.
module rr_arb2
  import sram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  // Grant decode; after any grant the pointer moves to the other port.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr_q == PORT0) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
    if (gnt[0]) begin
      ptr_d = PORT1;
    end else if (gnt[1]) begin
      ptr_d = PORT0;
    end
  end

  // Pointer register, starts at port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PORT0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between two requesters with round-robin arbitration,
// registered SRAM drive, optional post-reset array clear and per-port read return.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              init_done,
  output logic              csb_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out
);

  localparam state_e            RST_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                init_done_q, init_done_d;

  logic [1:0]          req, gnt;
  logic                acc, sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  logic                csb_n_q, csb_n_d, we_n_q, we_n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  tag_t                tag1_q, tag1_d, tag2_q;

  logic                p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

  // INIT walks the counter one past the last word so init_done follows the last clear write
  // by one cycle; init_done is registered so it reads 0 while rst is held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == DEPTH) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + (ADDR_W+1)'(1);
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = RST_STATE;
    endcase
    init_done_d = (state_d == ST_RUN);
  end

  // FSM, init counter and init_done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign req = {p1_valid, p0_valid} & {2{init_done_q}};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign p0_ready  = gnt[0];
  assign p1_ready  = gnt[1];
  assign acc       = |gnt;
  assign sel_we    = gnt[1] ? p1_we    : p0_we;
  assign sel_addr  = gnt[1] ? p1_addr  : p0_addr;
  assign sel_wdata = gnt[1] ? p1_wdata : p0_wdata;

  // Next SRAM drive: clear writes during INIT, granted access in RUN, else deselect and hold bus.
  always_comb begin
    csb_n_d = 1'b1;
    we_n_d  = 1'b1;
    addr_d  = addr_q;
    din_d   = din_q;
    tag1_d  = '0;
    if (state_q == ST_INIT && cnt_q != DEPTH) begin
      csb_n_d = 1'b0;
      we_n_d  = 1'b0;
      addr_d  = cnt_q[ADDR_W-1:0];
      din_d   = '0;
    end else if (acc) begin
      csb_n_d = 1'b0;
      we_n_d  = ~sel_we;
      addr_d  = sel_addr;
      din_d   = sel_wdata;
    end
    tag1_d.valid   = acc;
    tag1_d.is_read = acc & ~sel_we;
    tag1_d.port_id = gnt[1] ? PORT1 : PORT0;
  end

  // Response routing from the second tag stage; rdata holds between pulses.
  always_comb begin
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    if (tag2_q.valid && tag2_q.is_read) begin
      if (tag2_q.port_id == PORT1) begin
        p1_rvalid_d = 1'b1;
        p1_rdata_d  = sram_data_out;
      end else begin
        p0_rvalid_d = 1'b1;
        p0_rdata_d  = sram_data_out;
      end
    end
  end

  // SRAM drive, tag pipe and response registers; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      csb_n_q     <= 1'b1;
      we_n_q      <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      csb_n_q     <= csb_n_d;
      we_n_q      <= we_n_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign init_done    = init_done_q;
  assign csb_n        = csb_n_q;
  assign we_n         = we_n_q;
  assign addr         = addr_q;
  assign sram_data_in = din_q;
  assign p0_rvalid    = p0_rvalid_q;
  assign p1_rvalid    = p1_rvalid_q;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;

endmodule
